// File: rtl/uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and constants for the UART transmit framer.
//   - state encodings for the framer FSM
//   - LINE_BITS: data bits per frame on the wire
//   - calc_divisor(): rounded clocks-per-bit from clock and baud rate
// ----------------------------------------------------------------------------
package uart_tx_pkg;

    localparam int unsigned LINE_BITS = 8;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned BIT_IDX_W = $clog2(LINE_BITS);

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Clocks per line bit, rounded to nearest.
    function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter: counts 0..DIVISOR-1 while enabled and raises a
// combinational tick on the last count.
// Ports:
//   clk       in  system clock
//   res       in  asynchronous active-high reset
//   clr_i     in  synchronous clear to 0 (has priority over en_i)
//   en_i      in  count enable
//   tick_c_o  out one-cycle tick when count == DIVISOR-1 and enabled
// ----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned DIVISOR = 10
) (
    input  logic clk,
    input  logic res,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_c_o
);

    localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c_o = en_i && (cnt_q == CNT_LAST);

    // Next count: clear, wrap on tick, else increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_c_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// ----------------------------------------------------------------------------
// uart_tx_framer
// Serial transmit stage fed by the debug ring buffer. Accepts characters on a
// wr/data/busy handshake into a one-entry holding register and shifts them out
// as 8N1 / 8N2 frames (8E1 / 8E2 when UART_TX_PARITY_EN is defined).
//
// Build option:
//   UART_TX_PARITY_EN  insert an even-parity bit between data and stop bits
//
// Ports:
//   clk   in  system clock
//   res   in  asynchronous active-high reset
//   wr    in  character valid, sampled only while busy==0
//   data  in  DATA_WIDTH-bit character, LSB first, zero-padded to 8 bits
//   tx    out serial line, idle high (registered)
//   busy  out holding register full; wr ignored while high (registered)
// ----------------------------------------------------------------------------
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 921600,
    parameter int unsigned DATA_WIDTH = 7,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  tx,
    output logic                  busy
);

    localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ, BAUD);
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(LINE_BITS - 1);

    // Elaboration-time parameter checks.
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx_framer: CLK_FREQ/BAUD gives a divisor below 2");
    end
    if (DATA_WIDTH == 0 || DATA_WIDTH > LINE_BITS) begin : g_bad_width
        $error("uart_tx_framer: DATA_WIDTH must be 1..8");
    end

    state_t                 state_q, state_d;
    logic [LINE_BITS-1:0]   hold_q, hold_d;
    logic                   hold_vld_q, hold_vld_d;
    logic [LINE_BITS-1:0]   shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   stop2_q, stop2_d;
    logic                   tx_q, tx_d;

    logic accept_c;
    logic tick_c;
    logic cnt_clr_c;
    logic cnt_en_c;

    assign tx       = tx_q;
    assign busy     = hold_vld_q;
    assign accept_c = wr && !hold_vld_q;

    // Counter restarts on every state entry and is frozen in IDLE.
    assign cnt_clr_c = (state_d != state_q);
    assign cnt_en_c  = (state_q != ST_IDLE);

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clk      (clk),
        .res      (res),
        .clr_i    (cnt_clr_c),
        .en_i     (cnt_en_c),
        .tick_c_o (tick_c)
    );

    // Next-state, holding register and line-bit selection.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop2_d    = stop2_q;
        tx_d       = 1'b1;

        if (accept_c) begin
            hold_d     = LINE_BITS'(data);
            hold_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    shift_d    = hold_q;
                    hold_vld_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        stop2_d = 1'b0;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_c) begin
                    stop2_d = 1'b0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_c) begin
                    if (STOP_BITS == 2 && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else if (hold_vld_q) begin
                        // Back-to-back: next start bit follows with no idle gap.
                        shift_d    = hold_q;
                        hold_vld_d = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is registered, so decode the line level from the next state.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = ^shift_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end

`ifndef SYNTHESIS
    // Upstream must not present a character while busy; it would be lost.
    a_wr_while_busy: assert property (@(posedge clk) disable iff (res) !(wr && busy))
        else $warning("uart_tx_framer: wr asserted while busy, character dropped");
`endif

endmodule

// File: tb/tb_uart_tx_framer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_framer
// Directed bench for uart_tx_framer at CLK_FREQ=10 MHz, BAUD=1 MHz (10 clocks
// per bit). Two instances: STOP_BITS=1 and STOP_BITS=2, selected by 'sel'.
// Expected parity bit follows UART_TX_PARITY_EN when defined for the build.
// ----------------------------------------------------------------------------
module tb_uart_tx_framer;

    localparam int unsigned CLK_FREQ = 10_000_000;
    localparam int unsigned BAUD     = 1_000_000;
    localparam int          DIV      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int          PAR      = 1;
`else
    localparam int          PAR      = 0;
`endif

    logic       clk = 1'b0;
    logic       res;
    logic       wr;
    logic       sel;
    logic [6:0] data;
    logic       wr1, wr2;
    logic       tx1, tx2, busy1, busy2;
    logic       tx_sel, busy_sel;

    int n_cmp = 0;
    int n_err = 0;
    logic par_seen;

    assign wr1      = wr && !sel;
    assign wr2      = wr && sel;
    assign tx_sel   = sel ? tx2 : tx1;
    assign busy_sel = sel ? busy2 : busy1;

    always #5 clk = ~clk;

    uart_tx_framer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_WIDTH (7),
        .STOP_BITS  (1)
    ) u_dut1 (
        .clk  (clk),
        .res  (res),
        .wr   (wr1),
        .data (data),
        .tx   (tx1),
        .busy (busy1)
    );

    uart_tx_framer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_WIDTH (7),
        .STOP_BITS  (2)
    ) u_dut2 (
        .clk  (clk),
        .res  (res),
        .wr   (wr2),
        .data (data),
        .tx   (tx2),
        .busy (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line bits of one frame, index 0 = start bit; bits above the frame are 1.
    function automatic logic [11:0] frame_bits(input logic [6:0] ch);
        logic [11:0] f;
        logic [7:0]  d;
        f = '1;
        d = {1'b0, ch};
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (PAR != 0) f[9] = ^d;
        return f;
    endfunction

    function automatic int frame_len(input int stops);
        return 10 + PAR + stops - 1;
    endfunction

    // Pulse wr for one cycle; leaves time at the cycle the start bit begins.
    task automatic send(input string tag, input logic [6:0] ch);
        wr   = 1'b1;
        data = ch;
        step();
        wr = 1'b0;
        check({tag, "_busy_hi"}, busy_sel, 1'b1);
        check({tag, "_tx_latency"}, tx_sel, 1'b1);
        step();
        check({tag, "_busy_lo"}, busy_sel, 1'b0);
    endtask

    // Check tx every cycle for one frame, or two back-to-back frames when b2b
    // is set (the second character is offered the first cycle busy is low).
    task automatic run_line(input string tag, input logic [6:0] c1, input int stops,
                            input bit b2b, input logic [6:0] c2);
        logic [11:0] f1, f2;
        int len, total, bi;
        logic e;
        f1    = frame_bits(c1);
        f2    = frame_bits(c2);
        len   = frame_len(stops);
        total = (b2b ? 2 : 1) * len * DIV;
        for (int cyc = 0; cyc < total; cyc++) begin
            bi = cyc / DIV;
            e  = (bi < len) ? f1[bi] : f2[bi - len];
            check({tag, "_tx"}, tx_sel, e);
            if (bi == 9 && (cyc % DIV) == 5) par_seen = tx_sel;
            if (b2b && cyc == 0) begin
                wr   = 1'b1;
                data = c2;
            end
            if (b2b && cyc == 1) begin
                wr = 1'b0;
                check({tag, "_held_busy"}, busy_sel, 1'b1);
            end
            if (b2b && cyc == len * DIV) check({tag, "_b2b_busy_lo"}, busy_sel, 1'b0);
            step();
        end
        check({tag, "_idle_tx"}, tx_sel, 1'b1);
        check({tag, "_idle_busy"}, busy_sel, 1'b0);
    endtask

    // Count cycles with tx low over a window; must stay idle.
    task automatic expect_quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_sel !== 1'b1) lows++;
            step();
        end
        check({tag, "_quiet"}, lows, 0);
        check({tag, "_quiet_busy"}, busy_sel, 1'b0);
    endtask

    initial begin
        res      = 1'b1;
        wr       = 1'b0;
        sel      = 1'b0;
        data     = '0;
        par_seen = 1'b0;
        step();
        step();
        check("rst_tx1", tx1, 1'b1);
        check("rst_busy1", busy1, 1'b0);
        check("rst_tx2", tx2, 1'b1);
        check("rst_busy2", busy2, 1'b0);
        res = 1'b0;
        step();
        step();

        // Single character 'A'.
        send("t1", 7'h41);
        run_line("t1", 7'h41, 1, 1'b0, 7'h00);
        expect_quiet("t1", 20);

        // Parity cases (plain frames in the default build).
        send("t5a", 7'h07);
        run_line("t5a", 7'h07, 1, 1'b0, 7'h00);
`ifdef UART_TX_PARITY_EN
        check("t5a_parity", par_seen, 1'b1);
`endif
        send("t5b", 7'h03);
        run_line("t5b", 7'h03, 1, 1'b0, 7'h00);
`ifdef UART_TX_PARITY_EN
        check("t5b_parity", par_seen, 1'b0);
`endif

        // Back-to-back "Hi".
        send("t2", 7'h48);
        run_line("t2", 7'h48, 1, 1'b1, 7'h69);
        expect_quiet("t2", 20);

        // wr while busy is dropped; the held character still goes out intact.
        wr   = 1'b1;
        data = 7'h2A;
        step();
        data = 7'h7F;
        check("t3_busy_hi", busy1, 1'b1);
        step();
        wr = 1'b0;
        check("t3_busy_lo", busy1, 1'b0);
        run_line("t3", 7'h2A, 1, 1'b0, 7'h00);
        expect_quiet("t3", 3 * DIV * 11);

        // Reset during data bit 3 of 'U' with a second character held.
        send("t4", 7'h55);
        wr   = 1'b1;
        data = 7'h33;
        step();
        wr = 1'b0;
        check("t4_held_busy", busy1, 1'b1);
        for (int i = 1; i < 42; i++) step();
        check("t4_pre_rst_tx", tx1, 1'b0);
        #1;
        res = 1'b1;
        #1;
        check("t4_rst_tx", tx1, 1'b1);
        check("t4_rst_busy", busy1, 1'b0);
        step();
        res = 1'b0;
        expect_quiet("t4", 150);

        // Two stop bits on the second instance, followed back-to-back by 'A'.
        sel = 1'b1;
        step();
        send("t6", 7'h00);
        run_line("t6", 7'h00, 2, 1'b1, 7'h41);
        expect_quiet("t6", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
